// File: rtl/int_cntl_pkg.sv
// Shared definitions for the interrupt controller: register word offsets,
// service FSM encoding and the VECTOR valid-bit position.
package int_cntl_pkg;

  localparam logic [2:0] OFF_RAW    = 3'd0;
  localparam logic [2:0] OFF_MASK   = 3'd1;
  localparam logic [2:0] OFF_PEND   = 3'd2;
  localparam logic [2:0] OFF_VECTOR = 3'd3;
  localparam logic [2:0] OFF_EOI    = 3'd4;

  localparam int VEC_VALID_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERV,
    ST_ACKP,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports whether any eligible source exists and the
// lowest-indexed one.
module int_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_eligible,
  output logic               o_any,
  output logic [ID_W-1:0]    o_winner
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    o_any    = 1'b0;
    o_winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_eligible[i]) begin
        o_any    = 1'b1;
        o_winner = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_cntl_slave.sv
// Interrupt controller slave: latches source IRQs, raises CPU_IRQ, serves the
// VECTOR/EOI handshake over the IP-side register bus and pulses ACK back.
module int_cntl_slave
  import int_cntl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               HCLK,
  input  logic               HRESET_n,
  input  logic               IP_SEL,
  input  logic [31:0]        IP_ADDR,
  input  logic               IP_WRITE,
  input  logic [31:0]        IP_WDATA,
  output logic [31:0]        IP_RDATA,
  output logic               IP_ERROR,
  input  logic [NUM_SRC-1:0] IRQ,
  output logic [NUM_SRC-1:0] ACK,
  output logic               CPU_IRQ
);

  state_t               r_state;
  logic [NUM_SRC-1:0]   r_pend;
  logic [NUM_SRC-1:0]   r_mask;
  logic [ID_W-1:0]      r_cur_id;
  logic                 r_cpu_irq;

  logic [2:0]           w_off;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_vec_rd;
  logic                 w_eoi_hit;
  logic [NUM_SRC-1:0]   w_cur_oh;
  logic [NUM_SRC-1:0]   w_eligible;
  logic                 w_any;
  logic [ID_W-1:0]      w_winner;
  logic [NUM_SRC-1:0]   w_set_inh;
  logic [NUM_SRC-1:0]   w_clr;
  logic [NUM_SRC-1:0]   w_pend_nxt;
  logic [31:0]          w_rdata;
  logic                 w_unused;

  assign w_off     = IP_ADDR[4:2];
  assign IP_ERROR  = (IP_ADDR[9:5] != 5'd0) || (w_off > OFF_EOI);
  assign w_wr      = IP_SEL & IP_WRITE & ~IP_ERROR;
  assign w_rd      = IP_SEL & ~IP_WRITE & ~IP_ERROR;
  assign w_vec_rd  = w_rd && (w_off == OFF_VECTOR);
  assign w_eoi_hit = w_wr && (w_off == OFF_EOI) && (IP_WDATA[ID_W-1:0] == r_cur_id);
  assign w_cur_oh  = NUM_SRC'(1) << r_cur_id;
  assign w_eligible = r_pend & r_mask;
  assign w_unused  = ^{IP_ADDR[31:10], IP_ADDR[1:0], IP_WDATA};

  int_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .i_eligible (w_eligible),
    .o_any      (w_any),
    .o_winner   (w_winner)
  );

  // The serviced source must not re-latch while its ACK/guard is in flight.
  always_comb begin
    w_set_inh = '0;
    w_clr     = '0;
    if (r_state == ST_ACKP || r_state == ST_HOLD) w_set_inh = w_cur_oh;
    if (r_state == ST_ACKP) w_clr = w_cur_oh;
  end

  assign w_pend_nxt = (r_pend | (IRQ & ~w_set_inh)) & ~w_clr;

  always_ff @(posedge HCLK or negedge HRESET_n) begin
    if (!HRESET_n) begin
      r_pend <= '0;
      r_mask <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_wr && w_off == OFF_MASK) r_mask <= IP_WDATA[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESET_n) begin
    if (!HRESET_n) begin
      r_state   <= ST_IDLE;
      r_cur_id  <= '0;
      r_cpu_irq <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_state   <= ST_REQ;
          r_cpu_irq <= 1'b1;
        end
        ST_REQ: if (!w_any) begin
          r_state   <= ST_IDLE;
          r_cpu_irq <= 1'b0;
        end else if (w_vec_rd) begin
          r_state   <= ST_SERV;
          r_cur_id  <= w_winner;
          r_cpu_irq <= 1'b0;
        end
        ST_SERV: if (w_eoi_hit) r_state <= ST_ACKP;
        ST_ACKP: r_state <= ST_HOLD;
        ST_HOLD: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign CPU_IRQ = r_cpu_irq;
  assign ACK     = (r_state == ST_ACKP) ? w_cur_oh : '0;

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_off)
        OFF_RAW:  w_rdata[NUM_SRC-1:0] = IRQ;
        OFF_MASK: w_rdata[NUM_SRC-1:0] = r_mask;
        OFF_PEND: w_rdata[NUM_SRC-1:0] = r_pend;
        OFF_VECTOR: if (r_state == ST_REQ && w_any) begin
          w_rdata[VEC_VALID_BIT] = 1'b1;
          w_rdata[ID_W-1:0]      = w_winner;
        end
        default: w_rdata = '0;
      endcase
    end
  end

  assign IP_RDATA = w_rdata;

endmodule
